// File: rtl/cpu_step_sequencer_pkg.sv
// Shared types for the CPU program sequencer: control word, program word, FSM states, ALU ops.
package cpu_step_sequencer_pkg;

    localparam int unsigned CTRL_W = 10;
    localparam int unsigned WORD_W = 11;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_OR  = 2'd3;

    typedef struct packed {
        logic       wr_a;
        logic [1:0] sel_a;
        logic [1:0] sel_b;
        logic [1:0] alu_op;
        logic       imm;
        logic [1:0] sel_r;
    } ctrl_t;

    typedef struct packed {
        logic  halt;
        ctrl_t ctrl;
    } prog_word_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_SETUP = 3'd2,
        S_STEP  = 3'd3,
        S_HALT  = 3'd4
    } seq_state_e;

endpackage

// File: rtl/cpu_step_sequencer_debouncer.sv
// key_debouncer: 2-flop synchroniser, stability counter and one-cycle press pulse
// on the debounced released->pressed edge of an active-low key.
module key_debouncer #(
    parameter int unsigned DEBOUNCE_CYC = 500000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    output logic o_press
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    // Level follows the synchronised key only after DEBOUNCE_CYC consecutive differing samples
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYC - 1)) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
                r_press <= r_level;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/cpu_step_sequencer.sv
// Program sequencer: stores control words and issues one word plus a cpu_step strobe per key press.
// Optional auto-run prescaler is enabled with `define CPU_SEQ_AUTO_RUN_EN.
module cpu_step_sequencer
    import cpu_step_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned DEBOUNCE_CYC = 500000,
    parameter int unsigned SETUP_CYC    = 2,
    parameter int unsigned RUN_DIV      = 25000000
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_step_key_n,
    input  logic                     i_pc_clr,
    input  logic                     i_run,
    input  logic                     i_prog_we,
    input  logic [$clog2(DEPTH)-1:0] i_prog_addr,
    input  logic [WORD_W-1:0]        i_prog_wdata,
    output ctrl_t                    o_ctrl,
    output logic                     o_cpu_step,
    output logic [$clog2(DEPTH)-1:0] o_pc,
    output logic                     o_halted,
    output logic                     o_busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned SW = $clog2(SETUP_CYC + 1);

    seq_state_e    r_state;
    seq_state_e    w_state_nx;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] w_pc_nx;
    ctrl_t         r_ctrl;
    ctrl_t         w_ctrl_nx;
    logic [SW-1:0] r_setup_cnt;
    logic [SW-1:0] w_setup_cnt_nx;
    logic          r_cpu_step;
    logic          r_halted;
    logic          r_busy;
    logic          w_mem_we;
    logic          w_press;
    logic          w_tick;
    prog_word_t    w_rd_word;
    prog_word_t    r_mem [DEPTH];

    key_debouncer #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_debouncer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_key_n (i_step_key_n),
        .o_press (w_press)
    );

`ifdef CPU_SEQ_AUTO_RUN_EN
    localparam int unsigned PW = $clog2(RUN_DIV);

    logic [PW-1:0] r_presc;

    // Free-running tick source while run is held; cleared whenever run drops
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_presc <= '0;
        end else if (!i_run || (r_presc == PW'(RUN_DIV - 1))) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    assign w_tick = i_run && (r_presc == PW'(RUN_DIV - 1));
`else
    logic w_unused_run;

    assign w_unused_run = i_run & (RUN_DIV > 0);
    assign w_tick       = 1'b0;
`endif

    // Program memory: no reset, written only while the sequencer is idle or halted
    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            r_mem[i_prog_addr] <= prog_word_t'(i_prog_wdata);
        end
    end

    assign w_rd_word = r_mem[r_pc];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_pc        <= '0;
            r_ctrl      <= '0;
            r_setup_cnt <= '0;
            r_cpu_step  <= 1'b0;
            r_halted    <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_pc        <= w_pc_nx;
            r_ctrl      <= w_ctrl_nx;
            r_setup_cnt <= w_setup_cnt_nx;
            r_cpu_step  <= (w_state_nx == S_STEP);
            r_halted    <= (w_state_nx == S_HALT);
            r_busy      <= (w_state_nx == S_FETCH) || (w_state_nx == S_SETUP) ||
                           (w_state_nx == S_STEP);
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_pc_nx        = r_pc;
        w_ctrl_nx      = r_ctrl;
        w_setup_cnt_nx = r_setup_cnt;
        w_mem_we       = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_mem_we = i_prog_we;
                if (w_press || w_tick) begin
                    w_state_nx = S_FETCH;
                end
            end
            S_FETCH: begin
                if (w_rd_word.halt) begin
                    w_state_nx = S_HALT;
                end else begin
                    w_ctrl_nx      = w_rd_word.ctrl;
                    w_setup_cnt_nx = '0;
                    w_state_nx     = S_SETUP;
                end
            end
            S_SETUP: begin
                if (r_setup_cnt == SW'(SETUP_CYC - 1)) begin
                    w_state_nx = S_STEP;
                end else begin
                    w_setup_cnt_nx = r_setup_cnt + SW'(1);
                end
            end
            S_STEP: begin
                w_pc_nx    = r_pc + AW'(1);
                w_state_nx = S_IDLE;
            end
            S_HALT: begin
                w_mem_we = i_prog_we;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        // pc_clr overrides every state; an already-issued strobe still completes
        if (i_pc_clr) begin
            w_pc_nx    = '0;
            w_state_nx = S_IDLE;
        end
    end

    assign o_ctrl     = r_ctrl;
    assign o_cpu_step = r_cpu_step;
    assign o_pc       = r_pc;
    assign o_halted   = r_halted;
    assign o_busy     = r_busy;

endmodule
